// File: rtl/crypto_sign_sdiv_mbdk_seq.sv
// Signed-by-unsigned restoring divider, one quotient bit per cycle, C truncation semantics.
// Latency DW+1 edges after accept (1 edge for zero divisor, or |din0|<din1 when CRYPTO_SIGN_SDIV_EARLY_EXIT_EN is defined); result held while out_ready=0.
module crypto_sign_sdiv_mbdk_seq #(
    parameter int ID             = 1,
    parameter int DIVIDEND_WIDTH = 17,
    parameter int DIVISOR_WIDTH  = 8
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIVIDEND_WIDTH-1:0]  din0,
    input  logic [DIVISOR_WIDTH-1:0]   din1,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIVIDEND_WIDTH-1:0]  quot,
    output logic [DIVISOR_WIDTH:0]     rem,
    output logic                       div_zero
);
    localparam int DW  = DIVIDEND_WIDTH;
    localparam int DVW = DIVISOR_WIDTH;
    localparam int CW  = $clog2(DW);

    if (ID < 0) begin : g_id_check
        $error("ID must be non-negative");
    end

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    mag_q, mag_d;      // dividend magnitude, refilled with quotient bits from the LSB
    logic [DVW:0]     pr_q, pr_d;
    logic [DVW-1:0]   divisor_q, divisor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic [DW-1:0]    quot_q, quot_d;
    logic [DVW:0]     rem_q, rem_d;
    logic             div_zero_q, div_zero_d;

    logic [DW-1:0]    abs_in;
    logic [DVW:0]     shifted;
    logic [DVW:0]     diff;
    logic             ge;

    always_comb begin
        abs_in  = din0[DW-1] ? (~din0 + 1'b1) : din0;
        shifted = {pr_q[DVW-1:0], mag_q[DW-1]};
        diff    = shifted - {1'b0, divisor_q};
        ge      = (shifted >= {1'b0, divisor_q});

        state_d    = state_q;
        mag_d      = mag_q;
        pr_d       = pr_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        zero_d     = zero_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    neg_d     = din0[DW-1];
                    mag_d     = abs_in;
                    divisor_d = din1;
                    pr_d      = '0;
                    cnt_d     = CW'(DW - 1);
                    zero_d    = (din1 == '0);
                    if (din1 == '0) begin
                        state_d = FIX;
`ifdef CRYPTO_SIGN_SDIV_EARLY_EXIT_EN
                    end else if (abs_in < DW'(din1)) begin
                        // Quotient is zero and the whole magnitude is the remainder.
                        mag_d   = '0;
                        pr_d    = abs_in[DVW:0];
                        state_d = FIX;
`endif
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                pr_d  = ge ? diff : shifted;
                mag_d = {mag_q[DW-2:0], ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quot_d = '1;
                    rem_d  = '0;
                end else begin
                    quot_d = neg_q ? (~mag_q + 1'b1) : mag_q;
                    rem_d  = neg_q ? (~pr_q + 1'b1) : pr_q;
                end
                div_zero_d = zero_q;
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            pr_q       <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            pr_q       <= pr_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            zero_q     <= zero_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign div_zero  = div_zero_q;

endmodule
